// File: rtl/debounce_ena.sv
// Purpose: push-button debouncer sampled on ena_db ticks; accepts a new level after N_STABLE agreeing samples.
// Latency: 2 clk synchroniser + N_STABLE ticks; btn_db, press and release_pulse are registered on the accepting edge.
// Backpressure: none; ena_db is a free-running sample strobe and the pulses carry no handshake.
`timescale 1ns/1ps

module debounce_ena #(
    parameter int N_STABLE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic ena_db,
    input  logic btn_in,
    output logic btn_db,
    output logic press,
    // 'release' is a reserved word in SystemVerilog, so the release pulse carries a suffix
    output logic release_pulse
);

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        WAIT_HI   = 2'd1,
        STABLE_HI = 2'd2,
        WAIT_LO   = 2'd3
    } state_t;

    // cnt holds the number of agreeing samples seen so far in a WAIT state;
    // reaching N_LAST means the sample being taken now is the N_STABLE-th.
    localparam logic [3:0] N_LAST = 4'(N_STABLE - 1);

    logic   s1;
    logic   s2;
    state_t state;
    logic [3:0] cnt;

    // Two-flop synchroniser for the asynchronous button, clocked every cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= btn_in;
            s2 <= s1;
        end
    end

    // Debounce FSM: advances only on ena_db, outputs registered alongside the state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= STABLE_LO;
            cnt           <= 4'd0;
            btn_db        <= 1'b0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            press         <= 1'b0;
            release_pulse <= 1'b0;
            if (ena_db) begin
                case (state)
                    STABLE_LO: begin
                        if (s2) begin
                            if (N_STABLE == 1) begin
                                state  <= STABLE_HI;
                                cnt    <= 4'd0;
                                btn_db <= 1'b1;
                                press  <= 1'b1;
                            end else begin
                                state <= WAIT_HI;
                                cnt   <= 4'd1;
                            end
                        end
                    end
                    WAIT_HI: begin
                        if (!s2) begin
                            // one disagreeing sample cancels the attempt
                            state <= STABLE_LO;
                            cnt   <= 4'd0;
                        end else if (cnt == N_LAST) begin
                            state  <= STABLE_HI;
                            cnt    <= 4'd0;
                            btn_db <= 1'b1;
                            press  <= 1'b1;
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end
                    STABLE_HI: begin
                        if (!s2) begin
                            if (N_STABLE == 1) begin
                                state         <= STABLE_LO;
                                cnt           <= 4'd0;
                                btn_db        <= 1'b0;
                                release_pulse <= 1'b1;
                            end else begin
                                state <= WAIT_LO;
                                cnt   <= 4'd1;
                            end
                        end
                    end
                    WAIT_LO: begin
                        if (s2) begin
                            state <= STABLE_HI;
                            cnt   <= 4'd0;
                        end else if (cnt == N_LAST) begin
                            state         <= STABLE_LO;
                            cnt           <= 4'd0;
                            btn_db        <= 1'b0;
                            release_pulse <= 1'b1;
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end
                    default: begin
                        state  <= STABLE_LO;
                        cnt    <= 4'd0;
                        btn_db <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_debounce_ena.sv
// Purpose: self-checking bench for debounce_ena with N_STABLE=4 and N_STABLE=1 instances.
// Latency: expectations come from a run-length reference model, queued per cycle and checked after each edge.
// Backpressure: not applicable; stimulus is a free-running sample strobe.
`timescale 1ns/1ps

module tb_debounce_ena;

    logic clk;
    logic rst;
    logic ena_db, btn_in, btn_db, press, release_pulse;
    logic ena1, btn1, db1, press1, rel1;

    debounce_ena #(.N_STABLE(4)) dut (
        .clk(clk), .rst(rst), .ena_db(ena_db), .btn_in(btn_in),
        .btn_db(btn_db), .press(press), .release_pulse(release_pulse)
    );

    debounce_ena #(.N_STABLE(1)) dut1 (
        .clk(clk), .rst(rst), .ena_db(ena1), .btn_in(btn1),
        .btn_db(db1), .press(press1), .release_pulse(rel1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: counts consecutive tick samples that disagree with the
    // debounced level; N of them in a row flip the level.
    typedef struct {
        bit s1; bit s2; bit db; bit pr; bit rl; int run;
    } model_t;

    typedef struct {
        bit db; bit pr; bit rl; bit db1; bit pr1; bit rl1;
    } exp_t;

    typedef struct {
        bit rst; bit btn; int period; int ticks;
        int exp_press; int exp_rel; bit exp_db; int exp_edge;
    } seg_t;

    model_t m0, m1;
    exp_t   sbq[$];
    int checks = 0;
    int errors = 0;
    int seg_press, seg_rel, pr1_cnt, rl1_cnt;

    function automatic model_t step(model_t m, bit r, bit e, bit b, int n);
        model_t q = m;
        if (r) begin
            q = '{0, 0, 0, 0, 0, 0};
            return q;
        end
        q.pr = 0;
        q.rl = 0;
        if (e) begin
            if (m.s2 != m.db) begin
                q.run = m.run + 1;
                if (q.run == n) begin
                    q.db  = ~m.db;
                    q.pr  = q.db;
                    q.rl  = ~q.db;
                    q.run = 0;
                end
            end else begin
                q.run = 0;
            end
        end
        q.s2 = m.s1;
        q.s1 = b;
        return q;
    endfunction

    task automatic chk(string nm, int act, int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
        end
    endtask

    // Drive one cycle's inputs at the falling edge, queue the model's view of
    // the coming rising edge, then compare once that edge has happened.
    task automatic cycle(bit r, bit e, bit b, bit e1, bit b1);
        exp_t x;
        rst = r; ena_db = e; btn_in = b; ena1 = e1; btn1 = b1;
        m0 = step(m0, r, e, b, 4);
        m1 = step(m1, r, e1, b1, 1);
        x = '{m0.db, m0.pr, m0.rl, m1.db, m1.pr, m1.rl};
        sbq.push_back(x);
        @(posedge clk);
        @(negedge clk);
        x = sbq.pop_front();
        chk("btn_db", int'(btn_db), int'(x.db));
        chk("press", int'(press), int'(x.pr));
        chk("release", int'(release_pulse), int'(x.rl));
        chk("db1", int'(db1), int'(x.db1));
        chk("press1", int'(press1), int'(x.pr1));
        chk("release1", int'(rel1), int'(x.rl1));
        seg_press += int'(press);
        seg_rel   += int'(release_pulse);
        pr1_cnt   += int'(press1);
        rl1_cnt   += int'(rel1);
    endtask

    // Run a tick pattern on the N=4 instance: ena_db on the last cycle of each period
    task automatic run_ticks(bit r, bit b, int period, int ticks);
        for (int c = 0; c < period * ticks; c++)
            cycle(r, (c % period) == period - 1, b, 1'b0, 1'b0);
    endtask

    initial begin
        seg_t segs[10];
        int   pulse_at;
        bit   hist[$];
        int   durs[6];

        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        seg_t segs[10];
        int   pulse_at;
        int   durs[6];
        bit   hist[$];
        bit   lvl;

        //           rst btn per tk  prs rel db  edge
        segs[0] = '{1, 1, 2,  5, 0, 0, 0, -1};  // reset held, button pressed, ena toggling
        segs[1] = '{0, 1, 10, 4, 1, 0, 1, 39};  // clean press: accepted on the 4th tick
        segs[2] = '{0, 0, 10, 4, 0, 1, 0, 39};  // clean release
        segs[3] = '{0, 1, 10, 2, 0, 0, 0, -1};  // bounce: two high ticks...
        segs[4] = '{0, 0, 10, 1, 0, 0, 0, -1};  // ...one low tick cancels
        segs[5] = '{0, 1, 10, 3, 0, 0, 0, -1};  // three fresh high ticks
        segs[6] = '{0, 1, 10, 1, 1, 0, 1, 9};   // fourth consecutive high tick
        segs[7] = '{0, 0, 10, 3, 0, 0, 1, -1};  // release attempt, three ticks
        segs[8] = '{0, 1, 10, 1, 0, 0, 1, -1};  // one high tick cancels it
        segs[9] = '{0, 0, 10, 4, 0, 1, 0, 39};  // full release

        m0 = '{0, 0, 0, 0, 0, 0};
        m1 = '{0, 0, 0, 0, 0, 0};
        rst = 1'b1; ena_db = 1'b0; btn_in = 1'b1; ena1 = 1'b0; btn1 = 1'b0;
        #1;
        chk("reset_btn_db", int'(btn_db), 0);
        chk("reset_press", int'(press), 0);
        chk("reset_release", int'(release_pulse), 0);
        chk("reset_cnt", int'(dut.cnt), 0);
        @(negedge clk);

        for (int s = 0; s < 10; s++) begin
            seg_press = 0;
            seg_rel   = 0;
            pulse_at  = -1;
            for (int c = 0; c < segs[s].period * segs[s].ticks; c++) begin
                cycle(segs[s].rst, (c % segs[s].period) == segs[s].period - 1,
                      segs[s].btn, 1'b0, 1'b0);
                if ((press || release_pulse) && pulse_at < 0) pulse_at = c;
            end
            chk($sformatf("seg%0d_presses", s), seg_press, segs[s].exp_press);
            chk($sformatf("seg%0d_releases", s), seg_rel, segs[s].exp_rel);
            chk($sformatf("seg%0d_btn_db", s), int'(btn_db), int'(segs[s].exp_db));
            chk($sformatf("seg%0d_pulse_cycle", s), pulse_at, segs[s].exp_edge);
        end

        // Glitch of 3 cycles falling entirely between two ticks
        seg_press = 0;
        for (int c = 0; c < 20; c++)
            cycle(1'b0, (c % 10) == 9, (c >= 2 && c <= 4), 1'b0, 1'b0);
        chk("glitch_btn_db", int'(btn_db), 0);
        chk("glitch_cnt", int'(dut.cnt), 0);
        chk("glitch_presses", seg_press, 0);

        // Async reset after 3 of 4 high ticks
        run_ticks(1'b0, 1'b1, 10, 3);
        chk("waithi_cnt", int'(dut.cnt), 3);
        rst = 1'b1;
        #1;
        chk("arst_hi_btn_db", int'(btn_db), 0);
        chk("arst_hi_press", int'(press), 0);
        chk("arst_hi_cnt", int'(dut.cnt), 0);
        m0 = step(m0, 1'b1, 1'b0, 1'b0, 4);
        m1 = step(m1, 1'b1, 1'b0, 1'b0, 1);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        seg_press = 0;
        run_ticks(1'b0, 1'b1, 10, 3);
        chk("post_arst_3ticks_presses", seg_press, 0);
        chk("post_arst_3ticks_btn_db", int'(btn_db), 0);
        run_ticks(1'b0, 1'b1, 10, 1);
        chk("post_arst_4ticks_presses", seg_press, 1);
        chk("post_arst_4ticks_btn_db", int'(btn_db), 1);

        // Async reset during WAIT_LO clears a high btn_db immediately
        seg_rel = 0;
        run_ticks(1'b0, 1'b0, 10, 2);
        chk("waitlo_btn_db", int'(btn_db), 1);
        rst = 1'b1;
        #1;
        chk("arst_lo_btn_db", int'(btn_db), 0);
        chk("arst_lo_release", int'(release_pulse), 0);
        m0 = step(m0, 1'b1, 1'b0, 1'b0, 4);
        m1 = step(m1, 1'b1, 1'b0, 1'b0, 1);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        run_ticks(1'b0, 1'b0, 10, 5);
        chk("arst_lo_releases", seg_rel, 0);

        // N_STABLE=1 with ena held high: db1 follows btn1 two edges later
        durs = '{3, 1, 5, 2, 1, 4};
        pr1_cnt = 0;
        rl1_cnt = 0;
        lvl = 1'b0;
        hist.push_back(1'b0);
        hist.push_back(1'b0);
        for (int k = 0; k < 7; k++) begin
            int len;
            lvl = (k < 6) ? ~lvl : 1'b0;
            len = (k < 6) ? durs[k] : 5;
            for (int c = 0; c < len; c++) begin
                hist.push_back(lvl);
                cycle(1'b0, 1'b0, 1'b0, 1'b1, lvl);
                chk("n1_follow", int'(db1), int'(hist[$size(hist) - 3]));
            end
        end
        chk("n1_presses", pr1_cnt, 3);
        chk("n1_releases", rl1_cnt, 3);
        chk("n1_final_db", int'(db1), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
